// File: rtl/aes_link_ctrl.sv
// Sequencer between the RS232 receive path, the AES core and the RS232 transmit path.
// Assembles the key and data blocks, starts the AES core, and serialises each result MSB byte first.
module aes_link_ctrl #(
    parameter int unsigned TIMEOUT_W = 20,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [63:0]    rx_data,
    input  logic           rx_valid,
    output logic [127:0]   aes_key,
    output logic [127:0]   aes_din,
    output logic           aes_start,
    input  logic           aes_done,
    input  logic [127:0]   aes_dout,
    output logic [7:0]     tx_byte,
    output logic           tx_send,
    input  logic           tx_busy,
    output logic           key_valid,
    output logic           overrun,
    output logic           err,
    output logic [2:0]     state_dbg
);

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned PKT_W  = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(15);

    typedef enum logic [2:0] {
        ST_KEY0  = 3'd0,
        ST_KEY1  = 3'd1,
        ST_DAT0  = 3'd2,
        ST_DAT1  = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_SEND  = 3'd6,
        ST_TXW   = 3'd7
    } state_t;

    state_t               r_state;
    logic [BLK_W-1:0]     r_key;
    logic [BLK_W-1:0]     r_din;
    logic [BLK_W-1:0]     r_result;
    logic [IDX_W-1:0]     r_idx;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [BYTE_W-1:0]    r_tx_byte;
    logic                 r_tx_send;
    logic                 r_aes_start;
    logic                 r_key_valid;
    logic                 r_overrun;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [BLK_W-1:0]     w_key_nxt;
    logic [BLK_W-1:0]     w_din_nxt;
    logic [BLK_W-1:0]     w_result_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [TIMEOUT_W-1:0] w_wd_nxt;
    logic [BYTE_W-1:0]    w_tx_byte_nxt;
    logic                 w_tx_send_nxt;
    logic                 w_aes_start_nxt;
    logic                 w_key_valid_nxt;
    logic                 w_overrun_nxt;
    logic                 w_err_nxt;
    logic [BYTE_W-1:0]    w_byte_sel;
    logic                 w_busy_state;

    // Byte idx of the result, counted from the most significant end
    assign w_byte_sel = r_result[7'd127 - {r_idx, 3'b000} -: 8];

    assign w_busy_state = (r_state == ST_START) || (r_state == ST_WAIT) ||
                          (r_state == ST_SEND)  || (r_state == ST_TXW);

    always_comb begin
        w_state_nxt     = r_state;
        w_key_nxt       = r_key;
        w_din_nxt       = r_din;
        w_result_nxt    = r_result;
        w_idx_nxt       = r_idx;
        w_wd_nxt        = r_wd;
        w_tx_byte_nxt   = r_tx_byte;
        w_tx_send_nxt   = 1'b0;
        w_aes_start_nxt = 1'b0;
        w_key_valid_nxt = r_key_valid;
        w_overrun_nxt   = r_overrun;
        w_err_nxt       = r_err;

        case (r_state)
            ST_KEY0: begin
                if (rx_valid) begin
                    w_key_nxt[127:64] = rx_data;
                    w_state_nxt       = ST_KEY1;
                end
            end
            ST_KEY1: begin
                if (rx_valid) begin
                    w_key_nxt[63:0] = rx_data;
                    w_key_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DAT0;
                end
            end
            ST_DAT0: begin
                if (rx_valid) begin
                    w_din_nxt[127:64] = rx_data;
                    w_state_nxt       = ST_DAT1;
                end
            end
            ST_DAT1: begin
                if (rx_valid) begin
                    w_din_nxt[63:0] = rx_data;
                    w_state_nxt     = ST_START;
                end
            end
            ST_START: begin
                w_aes_start_nxt = 1'b1;
                w_wd_nxt        = '0;
                w_state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse beats a watchdog expiry in the same cycle
                if (aes_done) begin
                    w_result_nxt = aes_dout;
                    w_idx_nxt    = '0;
                    w_state_nxt  = ST_SEND;
                end else if (r_wd == WD_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DAT0;
                end else begin
                    w_wd_nxt = r_wd + TIMEOUT_W'(1);
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    w_tx_byte_nxt = w_byte_sel;
                    w_tx_send_nxt = 1'b1;
                    w_state_nxt   = ST_TXW;
                end
            end
            ST_TXW: begin
                // r_tx_send is high only in the first TXW cycle, before tx_busy is trustworthy
                if (!r_tx_send && !tx_busy) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_DAT0;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = ST_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_KEY0;
            end
        endcase

        if (rx_valid && w_busy_state) begin
            w_overrun_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_KEY0;
            r_key       <= '0;
            r_din       <= '0;
            r_result    <= '0;
            r_idx       <= '0;
            r_wd        <= '0;
            r_tx_byte   <= '0;
            r_tx_send   <= 1'b0;
            r_aes_start <= 1'b0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key       <= w_key_nxt;
            r_din       <= w_din_nxt;
            r_result    <= w_result_nxt;
            r_idx       <= w_idx_nxt;
            r_wd        <= w_wd_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_tx_send   <= w_tx_send_nxt;
            r_aes_start <= w_aes_start_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_overrun   <= w_overrun_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign aes_key   = r_key;
    assign aes_din   = r_din;
    assign aes_start = r_aes_start;
    assign tx_byte   = r_tx_byte;
    assign tx_send   = r_tx_send;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;
    assign err       = r_err;
    assign state_dbg = r_state;

endmodule
